// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: mode codes, FSM and counting-direction encodings.
package pwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pwm_state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_t;

endpackage

// File: rtl/pwm_compare_channel.sv
// One PWM channel: registered compare of the shared timebase against this channel's duty.
// Outside RUN the pin rests at the live polarity level (inactive).
module pwm_compare_channel #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [WIDTH-1:0] counter,
   input  logic [WIDTH-1:0] duty,
   input  logic             polarity,
   output logic             pwm_out
);

   logic pwm_next;

   always_comb begin
      pwm_next = polarity;
      if (run) begin
         pwm_next = (counter < duty) ^ polarity;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= pwm_next;
      end
   end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared edge/centre-aligned timebase, double-buffered period/duty/mode
// that switch over only at a period boundary, and CHANNELS registered compare outputs.
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      load,
   input  logic [WIDTH-1:0]          period,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic                      mode,
   input  logic [CHANNELS-1:0]       polarity,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic                      period_start,
   output logic                      update_done
);

   pwm_state_t                state_reg, state_next;
   pwm_dir_t                  dir_reg, dir_next;
   logic [WIDTH-1:0]          counter_reg, counter_next;

   logic [WIDTH-1:0]          period_act_reg, period_act_next;
   logic [CHANNELS*WIDTH-1:0] duty_act_reg, duty_act_next;
   logic                      mode_act_reg, mode_act_next;

   logic [WIDTH-1:0]          period_sh_reg, period_sh_next;
   logic [CHANNELS*WIDTH-1:0] duty_sh_reg, duty_sh_next;
   logic                      mode_sh_reg, mode_sh_next;
   logic                      pending_reg, pending_next;

   logic                      period_start_reg, period_start_next;
   logic                      update_done_reg, update_done_next;

   logic                      is_run;
   logic [WIDTH-1:0]          p_last;
   logic                      at_extreme;
   logic                      boundary;

   assign is_run = (state_reg == ST_RUN);

   // A programmed period of 0 behaves as 1, so the last count is then 0 as well.
   assign p_last = (period_act_reg == '0) ? '0 : period_act_reg - 1'b1;

   always_comb begin
      at_extreme = 1'b0;
      if (mode_act_reg == MODE_CENTER) begin
         at_extreme = (counter_reg == '0) && (dir_reg == DIR_DOWN);
      end else begin
         at_extreme = (counter_reg >= p_last);
      end
   end

   assign boundary = is_run && enable && at_extreme;

   // Next-state logic for the FSM, timebase, buffers and status pulses.
   always_comb begin
      state_next        = state_reg;
      dir_next          = dir_reg;
      counter_next      = counter_reg;
      period_act_next   = period_act_reg;
      duty_act_next     = duty_act_reg;
      mode_act_next     = mode_act_reg;
      period_sh_next    = period_sh_reg;
      duty_sh_next      = duty_sh_reg;
      mode_sh_next      = mode_sh_reg;
      pending_next      = pending_reg;
      update_done_next  = 1'b0;
      period_start_next = is_run && (counter_reg == '0) && (dir_reg == DIR_UP);

      case (state_reg)
         ST_IDLE: if (enable) state_next = ST_RUN;
         ST_RUN:  if (!enable) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      // Both modes naturally restart at 0/up after a boundary, which also covers a mode switch.
      if (!is_run || !enable || boundary) begin
         counter_next = '0;
         dir_next     = DIR_UP;
      end else if (mode_act_reg == MODE_EDGE) begin
         counter_next = counter_reg + 1'b1;
      end else if (dir_reg == DIR_UP) begin
         if (counter_reg >= p_last) begin
            dir_next = DIR_DOWN;
         end else begin
            counter_next = counter_reg + 1'b1;
         end
      end else if (counter_reg != '0) begin
         counter_next = counter_reg - 1'b1;
      end

      if (!is_run) begin
         if (load) begin
            period_act_next  = period;
            duty_act_next    = duty;
            mode_act_next    = mode;
            period_sh_next   = period;
            duty_sh_next     = duty;
            mode_sh_next     = mode;
            pending_next     = 1'b0;
            update_done_next = 1'b1;
         end
      end else begin
         if (boundary && pending_reg) begin
            period_act_next  = period_sh_reg;
            duty_act_next    = duty_sh_reg;
            mode_act_next    = mode_sh_reg;
            pending_next     = 1'b0;
            update_done_next = 1'b1;
         end
         // Applied after the transfer so a load on the boundary cycle waits for the next one.
         if (load) begin
            period_sh_next = period;
            duty_sh_next   = duty;
            mode_sh_next   = mode;
            pending_next   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         dir_reg          <= DIR_UP;
         counter_reg      <= '0;
         period_act_reg   <= '0;
         duty_act_reg     <= '0;
         mode_act_reg     <= MODE_EDGE;
         period_sh_reg    <= '0;
         duty_sh_reg      <= '0;
         mode_sh_reg      <= MODE_EDGE;
         pending_reg      <= 1'b0;
         period_start_reg <= 1'b0;
         update_done_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         dir_reg          <= dir_next;
         counter_reg      <= counter_next;
         period_act_reg   <= period_act_next;
         duty_act_reg     <= duty_act_next;
         mode_act_reg     <= mode_act_next;
         period_sh_reg    <= period_sh_next;
         duty_sh_reg      <= duty_sh_next;
         mode_sh_reg      <= mode_sh_next;
         pending_reg      <= pending_next;
         period_start_reg <= period_start_next;
         update_done_reg  <= update_done_next;
      end
   end

   assign period_start = period_start_reg;
   assign update_done  = update_done_reg;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         pwm_compare_channel #(
            .WIDTH (WIDTH)
         ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .run      (is_run),
            .counter  (counter_reg),
            .duty     (duty_act_reg[gi*WIDTH +: WIDTH]),
            .polarity (polarity[gi]),
            .pwm_out  (pwm_out[gi])
         );
      end
   endgenerate

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Parametrised multi-channel PWM generator. One shared timebase counter drives CHANNELS comparators.
Adds what the single-channel PWM lacks: edge- or centre-aligned counting, per-channel output polarity, a run enable, and double-buffered (shadow) period/duty/mode registers. Shadow values transfer only at a period boundary, so updates are glitch-free.
Sits between the control register bank and the motor/LED drive pins.

Parameters:
WIDTH, 16, bit width of period, duty and counter
CHANNELS, 4, number of PWM outputs sharing the timebase

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
enable  input  1  1 = run timebase; 0 = stop and idle outputs
load  input  1  1-cycle strobe: capture period/duty/mode into shadow registers
period  input  WIDTH  requested period in counts
duty  input  CHANNELS*WIDTH  requested duty per channel; channel i at bits [i*WIDTH +: WIDTH]
mode  input  1  0 = edge-aligned, 1 = centre-aligned
polarity  input  CHANNELS  per channel: 1 = invert output (sampled live, not shadowed)
pwm_out  output  CHANNELS  registered PWM outputs
period_start  output  1  1-cycle pulse, registered
update_done  output  1  1-cycle pulse when the shadow values became active

Behaviour:
- Reset: counter=0, dir=up, active and shadow registers=0, pending=0, state=IDLE, pwm_out=0, period_start=0, update_done=0.
- State machine IDLE/RUN:
  - IDLE→RUN when enable=1.
  - RUN→IDLE when enable=0, effective the next cycle; counter is forced to 0 and dir to up.
- In IDLE:
  - pwm_out = polarity (inactive level).
  - A load transfers directly into the active registers; update_done pulses the next cycle.
- Shadowing in RUN:
  - load sets pending=1 and overwrites the shadow registers; the last load before the boundary wins.
  - At a boundary with pending=1: active←shadow, pending←0, update_done pulses the next cycle.
  - A mode change restarts the counter at 0, dir up.
- Effective period P = max(period_act, 1).
- Edge mode:
  - Counter runs 0..P-1, then wraps to 0.
  - Boundary = cycle where counter==P-1.
  - Cycle length is P clocks.
- Centre mode:
  - Counter runs up 0..P-1, then down P-1..0; each extreme is held for 2 clocks.
  - Boundary = cycle where counter==0 and dir=down.
  - Cycle length is 2P clocks.
- Output law: pwm_out[i](t+1) = (counter(t) < duty_act[i]) XOR polarity[i].
  - Latency is 1 clock from counter to pin.
  - duty=0 → constantly inactive.
  - duty ≥ P → constantly active.
- period_start(t+1) = RUN and counter(t)==0 and dir(t)=up.
- Simultaneous load and boundary: the boundary transfers the old shadow contents; the new load is captured into shadow with pending=1 and applies at the next boundary.
- Comparisons are unsigned, WIDTH bits; the counter never exceeds P-1, so there is no overflow.
- Asynchronous reset mid-period returns every register to its reset value immediately.

Decomposition:
- Shared package pwm_pkg holds:
  - MODE_EDGE=1'b0 and MODE_CENTER=1'b0+1 constants;
  - state encoding ST_IDLE/ST_RUN.
- Sub-module pwm_compare_channel holds one channel's registered compare and polarity XOR. It is instantiated CHANNELS times via generate.
- Counter, shadow logic and FSM stay in the top level.

Test Plan:
1. Edge mode, WIDTH=16, P=5, duty ch0=2, polarity=0; enable → pwm_out[0] repeats high 2 / low 3 clocks; period_start every 5 clocks.
2. Centre mode, P=4, duty=1 → counter sequence 0,1,2,3,3,2,1,0; pwm_out high 2 of 8 clocks, centred on the counter minima.
3. Running P=8, duty=4; load duty=6 mid-period → old waveform held until the boundary; update_done pulses once; the next period is high 6 clocks.
4. Boundaries: duty=0 → always low; duty=8 and duty=100 with P=8 → always high; period=0 behaves as P=1; polarity=1 inverts each case.
5. load on the exact boundary cycle with pending=1 → the earlier shadow value applies now and the new one a period later; update_done pulses twice.
6. Drop enable mid-period → outputs go to the polarity level, counter=0; reset asserted mid-run → all outputs 0 asynchronously, and after release the shadow registers read 0.
